// File: rtl/rng_range_gen.sv
// rng_range_gen: WIDTH-bit xorshift generator whose output is reduced into [min_n, max_n)
// by a bit-serial restoring remainder, one seed bit per cycle.
module rng_range_gen #(
  parameter int WIDTH = 16,
  parameter int SHIFT_A = 7,
  parameter int SHIFT_B = 9,
  parameter int SHIFT_C = 8,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [WIDTH-1:0] min_n,
  input  logic [WIDTH-1:0] max_n,
  output logic [WIDTH-1:0] rand_int,
  output logic             valid,
  output logic             busy,
  output logic [WIDTH-1:0] seed
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, STEP, REDUCE, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] min_r, range_r;
  logic [WIDTH:0] rem, shifted, rem_next;
  logic [CW-1:0] cnt;
  function automatic logic [WIDTH-1:0] xorshift(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s ^ (s << SHIFT_A);
    t = t ^ (t >> SHIFT_B);
    t = t ^ (t << SHIFT_C);
    return t;
  endfunction
  // range_r == 0 marks the degenerate min_n >= max_n case, which pins the remainder to zero
  always_comb begin
    shifted = {rem[WIDTH-1:0], seed[cnt]};
    rem_next = range_r == '0 ? '0 : shifted >= {1'b0, range_r} ? shifted - {1'b0, range_r} : shifted;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      seed <= SEED_DEFAULT;
      rand_int <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      min_r <= '0;
      range_r <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_seed) seed <= seed_in == '0 ? SEED_DEFAULT : seed_in;
          if (req) begin
            state <= STEP;
            busy <= 1'b1;
          end
        end
        STEP: begin
          seed <= xorshift(seed);
          min_r <= min_n;
          range_r <= min_n >= max_n ? '0 : max_n - min_n;
          rem <= '0;
          cnt <= CW'(WIDTH - 1);
          state <= REDUCE;
        end
        REDUCE: begin
          rem <= rem_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          rand_int <= rem[WIDTH-1:0] + min_r;
          valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rng_range_gen.sv
// tb_rng_range_gen: directed draws with hand-computed results; a negedge monitor pops
// expected rand_int values from a queue whenever valid pulses.
module tb_rng_range_gen;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic load_seed = 1'b0;
  logic [15:0] seed_in = '0;
  logic req = 1'b0;
  logic [15:0] min_n = '0;
  logic [15:0] max_n = '0;
  logic [15:0] rand_int;
  logic valid, busy;
  logic [15:0] seed;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int n;

  rng_range_gen dut (
    .clock(clock), .reset(reset), .load_seed(load_seed), .seed_in(seed_in), .req(req),
    .min_n(min_n), .max_n(max_n), .rand_int(rand_int), .valid(valid), .busy(busy), .seed(seed)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: rand_int=%0d with no draw outstanding", rand_int);
      end else begin
        automatic logic [15:0] e = exp_q.pop_front();
        if (rand_int !== e) begin
          errors++;
          $display("FAIL rand_int: got %0d expected %0d", rand_int, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!valid && cnt < 60);
  endtask

  task automatic draw(input logic ld, input logic [15:0] sd, input logic [15:0] lo,
                      input logic [15:0] hi, input logic [15:0] exp_r, input logic [15:0] exp_s,
                      input string name);
    load_seed = ld;
    seed_in = sd;
    min_n = lo;
    max_n = hi;
    req = 1'b1;
    exp_q.push_back(exp_r);
    tick();
    load_seed = 1'b0;
    req = 1'b0;
    chk({name, "_busy"}, busy, 1);
    wait_valid(n);
    chk({name, "_latency"}, n, 18);
    chk({name, "_busy_done"}, busy, 0);
    chk({name, "_seed"}, seed, exp_s);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_seed", seed, 16'h0001);
    chk("rst_rand", rand_int, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);

    draw(1'b1, 16'd1, 16'd1, 16'd53, 16'd30, 16'h8181, "draw1");
    tick();
    draw(1'b0, 16'd0, 16'd1, 16'd53, 16'd14, 16'h6021, "draw2");
    tick();

    load_seed = 1'b1;
    seed_in = 16'h0000;
    tick();
    load_seed = 1'b0;
    chk("zero_seed_load", seed, 16'h0001);
    draw(1'b0, 16'd0, 16'd10, 16'd5, 16'd10, 16'h8181, "degen");
    tick();

    min_n = 16'd1;
    max_n = 16'd53;
    req = 1'b1;
    exp_q.push_back(16'd14);
    tick();
    tick();
    chk("held_step_seed", seed, 16'h6021);
    repeat (3) tick();
    max_n = 16'd2;
    load_seed = 1'b1;
    seed_in = 16'h1234;
    repeat (5) tick();
    load_seed = 1'b0;
    chk("busy_load_ignored", seed, 16'h6021);
    wait_valid(n);
    chk("held_first_valid", valid, 1);
    exp_q.push_back(16'd1);
    tick();
    req = 1'b0;
    chk("held_resample_busy", busy, 1);
    wait_valid(n);
    chk("held_interval", n + 1, 19);
    chk("range1_seed", seed, 16'hE999);
    tick();

    max_n = 16'd53;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_seed", seed, 16'h0001);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_rand", rand_int, 0);
    repeat (20) tick();
    draw(1'b0, 16'd0, 16'd1, 16'd53, 16'd30, 16'h8181, "after_abort");
    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
